// File: rtl/wb_dec_pkg.sv
// rtl/wb_dec_pkg.sv - shared types and constants for the Wishbone peripheral decoder
package wb_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WB_DW = 32;
  localparam logic [WB_DW-1:0] WB_DEFAULT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_dec_watchdog.sv
// rtl/wb_dec_watchdog.sv - per-transaction timeout counter, irq pulse and saturating timeout count
module wb_dec_watchdog
  import wb_dec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       fire,
  output logic       expire_o,
  output logic       irq_o,
  output logic [7:0] count_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;
  logic [7:0]  tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
    irq_d = fire;
    tc_d  = tc_q;
    if (fire && tc_q != 8'hFF) begin
      tc_d = tc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
      tc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
      tc_q  <= tc_d;
    end
  end

  assign expire_o = (cnt_q == LIMIT);
  assign irq_o    = irq_q;
  assign count_o  = tc_q;

endmodule

// File: rtl/wb_periph_decoder.sv
// rtl/wb_periph_decoder.sv - Wishbone slave decoder fanning one port out to NUM_SLAVES peripherals
// Define WB_DEC_TIMEOUT_EN to build the per-transaction watchdog.
module wb_periph_decoder
  import wb_dec_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB = 14,
  parameter int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [WB_DW-1:0] DEFAULT_DATA = WB_DEFAULT_DATA
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  output logic                        s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES*WB_DW-1:0] s_dat_i,
  output logic                        to_irq_o,
  output logic [7:0]                  to_count_o
);

  localparam logic [IDX_W:0]        NUM_SLAVES_L = (IDX_W + 1)'(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] STB_ONE      = NUM_SLAVES'(1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic                cyc_q, cyc_d;
  logic                ack_q, ack_d;
  logic [WB_DW-1:0]    dat_q, dat_d;

  logic [IDX_W-1:0]    req_idx;
  logic                req_unmapped;
  logic                abort;
  logic                sel_ack;
  logic [WB_DW-1:0]    sel_dat;
  logic                wd_expire;
  logic                unused_ok;

  assign req_idx      = wbs_adr_i[SEL_LSB +: IDX_W];
  assign req_unmapped = ({1'b0, req_idx} >= NUM_SLAVES_L);
  assign abort        = !wbs_cyc_i || !wbs_stb_i;
  assign sel_ack      = s_ack_i[idx_q];
  assign sel_dat      = s_dat_i[WB_DW*idx_q +: WB_DW];
  assign unused_ok    = ^{wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i};

  // Abort outranks the slave ack, which outranks the watchdog expiry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          idx_d = req_idx;
          if (req_unmapped) begin
            dat_d   = DEFAULT_DATA;
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            stb_d   = STB_ONE << req_idx;
            cyc_d   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (abort) begin
          stb_d   = '0;
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          dat_d   = sel_dat;
          stb_d   = '0;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (wd_expire) begin
          dat_d   = DEFAULT_DATA;
          stb_d   = '0;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        stb_d   = '0;
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      stb_q   <= '0;
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

`ifdef WB_DEC_TIMEOUT_EN
  logic wd_fire;
  assign wd_fire = (state_q == ST_BUSY) && !abort && !sel_ack && wd_expire;

  wb_dec_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (state_q != ST_BUSY),
    .en      (state_q == ST_BUSY),
    .fire    (wd_fire),
    .expire_o(wd_expire),
    .irq_o   (to_irq_o),
    .count_o (to_count_o)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expire  = 1'b0;
  assign to_irq_o   = 1'b0;
  assign to_count_o = '0;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_cyc_o   = cyc_q;
  assign s_stb_o   = stb_q;

endmodule

// File: tb/tb_wb_periph_decoder.sv
// tb/tb_wb_periph_decoder.sv - self-checking bench for wb_periph_decoder (timeout scenarios need WB_DEC_TIMEOUT_EN)
module tb_wb_periph_decoder;

  localparam int NS = 3;
  localparam int SEL_LSB = 14;
  localparam int IDXW = 2;
  localparam int TO = 8;
  localparam int NEVER = 100000;
  localparam logic [31:0] DEF = 32'hDEADBEEF;
`ifdef WB_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cyc_i, stb_i, we_i;
  logic [3:0] sel_i;
  logic [31:0] adr_i, dat_i;
  logic ack_o;
  logic [31:0] dat_o;
  logic s_cyc;
  logic [NS-1:0] s_stb;
  logic [NS-1:0] s_ack;
  logic [NS*32-1:0] s_dat;
  logic irq;
  logic [7:0] tcount;

  int total = 0;
  int bad = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  wb_periph_decoder #(
    .NUM_SLAVES(NS),
    .SEL_LSB(SEL_LSB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i), .wbs_we_i(we_i),
    .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .to_irq_o(irq), .to_count_o(tcount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: the slave acks in cycle lat of the strobe (lat >= NEVER means it never does).
  task automatic do_xfer(input logic [31:0] adr, input int lat, input logic [31:0] data,
                         input logic we, input bit stray);
    int idx;
    int exp_cyc;
    logic [31:0] exp_dat;
    bit exp_irq;
    logic [NS-1:0] exp_stb;
    logic [IDXW-1:0] field;
    field = adr[SEL_LSB +: IDXW];
    idx = int'(field);
    exp_stb = '0;
    exp_irq = 1'b0;
    if (idx >= NS) begin
      exp_cyc = 1;
      exp_dat = DEF;
    end else if (TO_EN && lat > TO) begin
      exp_stb[idx] = 1'b1;
      exp_cyc = TO + 1;
      exp_dat = DEF;
      exp_irq = 1'b1;
      if (model_count < 255) model_count++;
    end else begin
      exp_stb[idx] = 1'b1;
      exp_cyc = lat + 1;
      exp_dat = data;
    end
    s_dat = {$urandom, $urandom, $urandom};
    adr_i = adr; we_i = we; sel_i = 4'($urandom); dat_i = $urandom;
    cyc_i = 1'b1; stb_i = 1'b1;
    for (int c = 1; c <= exp_cyc; c++) begin
      step();
      if (c < exp_cyc) begin
        total++;
        if ({s_cyc, s_stb, ack_o, irq} !== {1'b1, exp_stb, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL busy_outputs cyc%0d: got cyc/stb/ack/irq=%b want %b", c,
                   {s_cyc, s_stb, ack_o, irq}, {1'b1, exp_stb, 1'b0, 1'b0});
        end
        s_ack = stray ? NS'($urandom) : '0;
        s_ack[idx] = 1'b0;
        if (c == lat) begin
          s_ack[idx] = 1'b1;
          s_dat[idx*32 +: 32] = data;
        end
      end else begin
        s_ack = '0;
        total++;
        if ({ack_o, irq, s_cyc, s_stb} !== {1'b1, exp_irq, 1'b0, {NS{1'b0}}}) begin
          bad++;
          $display("FAIL resp_outputs adr=%h: got ack/irq/cyc/stb=%b want %b", adr,
                   {ack_o, irq, s_cyc, s_stb}, {1'b1, exp_irq, 1'b0, {NS{1'b0}}});
        end
        if (!we) begin
          total++;
          if (dat_o !== exp_dat) begin
            bad++;
            $display("FAIL resp_data adr=%h: got %h want %h", adr, dat_o, exp_dat);
          end
        end
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    step();
    total++;
    if ({ack_o, irq, tcount} !== {1'b0, 1'b0, 8'(model_count)}) begin
      bad++;
      $display("FAIL after_resp: got ack/irq/count=%b/%b/%0d want 0/0/%0d", ack_o, irq, tcount, model_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc_i = 0; stb_i = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
    s_ack = '0; s_dat = '0;
    step(); step();
    total++;
    if ({ack_o, dat_o, s_cyc, s_stb, irq, tcount} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b dat=%h cyc=%b stb=%b irq=%b cnt=%0d want all 0",
               ack_o, dat_o, s_cyc, s_stb, irq, tcount);
    end
    rst = 1'b0;
    step();
    total++;
    if ({ack_o, s_cyc, s_stb} !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: got ack/cyc/stb=%b want 0", {ack_o, s_cyc, s_stb});
    end
  endtask

  task automatic test_mapped_read();
    do_xfer(32'h0000_8000, 3, 32'hCAFE0002, 1'b0, 1'b1);
  endtask

  task automatic test_unmapped();
    do_xfer(32'h0000_C000, 1, 32'h0, 1'b0, 1'b0);
    do_xfer(32'hFFFF_C123, 1, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    do_xfer(32'h0000_4000, TO, 32'h1234_5678, 1'b0, 1'b1);
    do_xfer(32'h0000_0010, TO - 1, 32'h0BAD_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    s_dat = {$urandom, $urandom, $urandom};
    adr_i = 32'h0000_4000; we_i = 0; cyc_i = 1; stb_i = 1;
    step();
    total++;
    if (s_stb !== 3'b010) begin
      bad++;
      $display("FAIL abort_strobe: got %b want 010", s_stb);
    end
    step(); step();
    stb_i = 1'b0;
    step();
    total++;
    if ({s_cyc, s_stb, ack_o, irq} !== '0) begin
      bad++;
      $display("FAIL abort_release: got cyc/stb/ack/irq=%b want 0", {s_cyc, s_stb, ack_o, irq});
    end
    cyc_i = 1'b0;
    step();
    total++;
    if ({s_cyc, s_stb, ack_o} !== '0) begin
      bad++;
      $display("FAIL abort_no_ack: got cyc/stb/ack=%b want 0", {s_cyc, s_stb, ack_o});
    end
    do_xfer(32'h0000_4000, 2, 32'hA5A5_0001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_xfer(32'h0000_0000, 1, 32'h1111_0000, 1'b0, 1'b0);
    do_xfer(32'h0000_4000, 1, 32'h2222_0001, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] adr;
      int lat;
      adr = $urandom;
`ifdef WB_DEC_TIMEOUT_EN
      lat = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, TO + 2));
`else
      lat = int'($urandom_range(1, TO + 4));
`endif
      do_xfer(adr, lat, $urandom, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_timeout();
`ifdef WB_DEC_TIMEOUT_EN
    for (int n = 0; n < 300; n++) begin
      do_xfer(32'h0000_0000, NEVER, 32'h0, 1'b0, 1'b0);
    end
    total++;
    if (tcount !== 8'd255) begin
      bad++;
      $display("FAIL timeout_saturate: got %0d want 255", tcount);
    end
`else
    for (int n = 0; n < 4; n++) begin
      do_xfer(32'h0000_8000, TO + 20, 32'h7E57_0000 + n, 1'b0, 1'b0);
    end
`endif
  endtask

  task automatic test_midreset();
    adr_i = 32'h0000_0000; cyc_i = 1; stb_i = 1;
    step(); step();
    rst = 1'b1;
    step();
    total++;
    if ({ack_o, dat_o, s_cyc, s_stb, irq, tcount} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got ack=%b dat=%h cyc=%b stb=%b irq=%b cnt=%0d want all 0",
               ack_o, dat_o, s_cyc, s_stb, irq, tcount);
    end
    cyc_i = 0; stb_i = 0; rst = 1'b0;
    model_count = 0;
    step();
    total++;
    if ({ack_o, s_cyc, s_stb} !== '0) begin
      bad++;
      $display("FAIL midreset_no_ack: got ack/cyc/stb=%b want 0", {ack_o, s_cyc, s_stb});
    end
    do_xfer(32'h0000_4000, 1, 32'h5555_AAAA, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_tie();
    test_abort();
    test_back_to_back();
    test_random();
    test_timeout();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
